xor_stream_cipher: RTL and testbench

Parametrised streaming XOR encrypter: each accepted data word is XORed with a rotated key and presented on a registered output with valid/ready flow control. Supports a fixed-key mode and a rolling-key mode, where the key rotates further after every word and restarts at each packet boundary (`s_last`). Sits between a byte/word source and a downstream sink in the encryption datapath. Replaces the single-byte, always-enabled XOR stage with a back-pressurable stream stage.

---
 rtl/xor_stream_cipher.sv | 137 +++++++++++++
 tb/tb_xor_stream_cipher.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_cipher.sv
// Streaming XOR encrypter with valid/ready flow control.
// Each accepted word is XORed with the current key and registered on the output.
// Fixed-key mode applies rotl(key, shift) to every word. Rolling-key mode rotates
// the key by a further `shift` after each word and restarts the schedule after
// a word flagged with s_last.
module xor_stream_cipher #(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = $clog2(DATA_W),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load,
  input  logic [DATA_W-1:0]  key,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               mode,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic [CNT_W-1:0]   word_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Left rotate with wrap. The word is doubled so the shift amount stays below
  // DATA_W, which keeps rotl(x, 0) == x without a shift by the full width.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                             input logic [SHIFT_W-1:0] n);
    logic [2*DATA_W-1:0] dbl;
    logic [SHIFT_W-1:0]  amt;
    amt = n & SHIFT_W'(DATA_W - 1);
    dbl = {x, x} << amt;
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

  logic [DATA_W-1:0]  base_key_q, base_key_d;
  logic [SHIFT_W-1:0] shift_r_q,  shift_r_d;
  logic               mode_r_q,   mode_r_d;
  logic [DATA_W-1:0]  cur_key_q,  cur_key_d;
  logic               key_ok_q,   key_ok_d;
  logic               m_valid_q,  m_valid_d;
  logic [DATA_W-1:0]  m_data_q,   m_data_d;
  logic               m_last_q,   m_last_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;

  logic               accept;
  logic [DATA_W-1:0]  eff_base;
  logic [DATA_W-1:0]  eff_cur;
  logic [SHIFT_W-1:0] eff_shift;
  logic               eff_mode;
  logic [CNT_W-1:0]   cnt_base;

  // Input side may take a word once a key exists and the output slot frees up.
  assign s_ready = key_ok_q && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;

  // Key context for this cycle: a key_load takes effect on a word accepted alongside it.
  always_comb begin
    eff_base  = base_key_q;
    eff_shift = shift_r_q;
    eff_mode  = mode_r_q;
    eff_cur   = cur_key_q;
    if (key_load) begin
      eff_base  = key;
      eff_shift = shift;
      eff_mode  = mode;
      eff_cur   = rotl(key, shift);
    end
  end

  // Next-state for key schedule, output register and word counter.
  always_comb begin
    base_key_d   = eff_base;
    shift_r_d    = eff_shift;
    mode_r_d     = eff_mode;
    cur_key_d    = eff_cur;
    key_ok_d     = key_ok_q | key_load;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    cnt_base     = key_load ? '0 : word_count_q;
    word_count_d = cnt_base;

    if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data ^ eff_cur;
      m_last_d  = s_last;
      if (cnt_base != CNT_MAX) begin
        word_count_d = cnt_base + CNT_W'(1);
      end
      if (eff_mode) begin
        // Rolling key: keep rotating within a packet, restart after its last word.
        cur_key_d = s_last ? rotl(eff_base, eff_shift) : rotl(eff_cur, eff_shift);
      end
    end
  end

  // State registers; reset discards any word in flight and forgets the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_key_q   <= '0;
      shift_r_q    <= '0;
      mode_r_q     <= 1'b0;
      cur_key_q    <= '0;
      key_ok_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      word_count_q <= '0;
    end else begin
      base_key_q   <= base_key_d;
      shift_r_q    <= shift_r_d;
      mode_r_q     <= mode_r_d;
      cur_key_q    <= cur_key_d;
      key_ok_q     <= key_ok_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      word_count_q <= word_count_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher: directed packets with literal expectations plus a
// randomized run checked every cycle against a word-index key model and a
// queue of expected output words.
module tb_xor_stream_cipher;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_load;
  logic [DW-1:0] key;
  logic [SW-1:0] shift;
  logic          mode;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] word_count;

  xor_stream_cipher #(.DATA_W(DW), .SHIFT_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key(key), .shift(shift),
    .mode(mode), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { logic [DW-1:0] d; logic l; } word_t;
  typedef struct { logic [DW-1:0] d; logic l; int c; } obs_t;

  word_t q[$];     // words the output register must present, in order
  obs_t  obs[$];   // words actually handed downstream
  word_t w;
  obs_t  o;

  // Model state: key context, index of the next word in the packet, counter.
  logic [DW-1:0] mb;
  int            ms;
  logic          mm;
  logic          mk;
  int            mn;
  int            mcnt;
  logic          exp_rdy;
  logic [DW-1:0] kk;

  function automatic logic [DW-1:0] rotl_m(input logic [DW-1:0] x, input int k);
    logic [DW-1:0] r;
    int a;
    a = k % DW;
    r = '0;
    for (int i = 0; i < DW; i++) r[(i + a) % DW] = x[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_obs(input int i, input logic [DW-1:0] d, input logic l);
    if (i >= obs.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL obs_%0d: got no word, expected 'h%0h last=%0d", i, d, l);
    end else begin
      chk($sformatf("obs_%0d_data", i), 32'(obs[i].d), 32'(d));
      chk($sformatf("obs_%0d_last", i), 32'(obs[i].l), 32'(l));
    end
  endtask

  // Per-cycle compare against the model, then advance the model over the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        mb = '0; ms = 0; mm = 1'b0; mk = 1'b0; mn = 0; mcnt = 0;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
      end else begin
        exp_rdy = mk && (q.size() == 0 || m_ready);
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("m_data", 32'(m_data), 32'(q[0].d));
          chk("m_last", 32'(m_last), 32'(q[0].l));
        end
        chk("word_count", 32'(word_count), 32'(mcnt));
        if (m_valid && m_ready) begin
          o.d = m_data; o.l = m_last; o.c = cyc;
          obs.push_back(o);
        end
        if (q.size() != 0 && m_ready) void'(q.pop_front());
        if (key_load) begin
          mb = key; ms = int'(shift); mm = mode; mk = 1'b1; mn = 0; mcnt = 0;
        end
        if (s_valid && exp_rdy) begin
          kk = mm ? rotl_m(mb, ms * (mn + 1)) : rotl_m(mb, ms);
          w.d = s_data ^ kk;
          w.l = s_last;
          q.push_back(w);
          if (mm) mn = s_last ? 0 : (mn + 1) % DW;
          if (mcnt < 2**CW - 1) mcnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [DW-1:0] k, input logic [SW-1:0] sh, input logic md);
    key = k; shift = sh; mode = md; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("send_accepted", 32'(acc), 1);
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key = '0; shift = '0; mode = 1'b0;
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    chk("reset_s_ready", 32'(s_ready), 0);
    chk("reset_m_valid", 32'(m_valid), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("nokey_s_ready", 32'(s_ready), 0);
    chk("nokey_m_valid", 32'(m_valid), 0);
    s_valid = 1'b0;

    // Fixed mode
    obs.delete();
    load_key(8'hA5, 3'd1, 1'b0);
    chk("ready_after_load", 32'(s_ready), 1);
    send(8'h00, 1'b0); send(8'hFF, 1'b0); send(8'h5A, 1'b0);
    repeat (2) tick();
    check_obs(0, 8'h4B, 1'b0); check_obs(1, 8'hB4, 1'b0); check_obs(2, 8'h11, 1'b0);
    chk("fixed_word_count", 32'(word_count), 3);

    // Rolling mode, back-to-back
    obs.delete();
    load_key(8'h01, 3'd1, 1'b1);
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    repeat (2) tick();
    check_obs(0, 8'h02, 1'b0); check_obs(1, 8'h04, 1'b0);
    check_obs(2, 8'h08, 1'b0); check_obs(3, 8'h10, 1'b0);
    if (obs.size() > 3) chk("roll_no_bubble", 32'(obs[3].c - obs[0].c), 3);

    // Shift zero and wrap
    obs.delete();
    load_key(8'h3C, 3'd0, 1'b0);
    send(8'h3C, 1'b0);
    load_key(8'h81, 3'd7, 1'b0);
    send(8'h00, 1'b0);
    repeat (2) tick();
    check_obs(0, 8'h00, 1'b0); check_obs(1, 8'hC0, 1'b0);

    // Packet restart
    obs.delete();
    load_key(8'h01, 3'd3, 1'b1);
    send(8'h00, 1'b0); send(8'h00, 1'b1); send(8'h00, 1'b0);
    repeat (2) tick();
    check_obs(0, 8'h08, 1'b0); check_obs(1, 8'h40, 1'b1); check_obs(2, 8'h08, 1'b0);

    // Back-pressure with a key_load during the stall
    obs.delete();
    load_key(8'h5A, 3'd2, 1'b0);
    m_ready = 1'b0;
    send(8'h0F, 1'b0);
    s_valid = 1'b1; s_data = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin key = 8'hFF; shift = 3'd0; mode = 1'b0; key_load = 1'b1; end
      @(negedge clk);
      chk("stall_s_ready", 32'(s_ready), 0);
      chk("stall_m_valid", 32'(m_valid), 1);
      chk("stall_m_data", 32'(m_data), 'h66);
      tick();
      key_load = 1'b0;
    end
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (2) tick();
    chk("stall_obs_count", 32'(obs.size()), 2);
    check_obs(0, 8'h66, 1'b0); check_obs(1, 8'hF0, 1'b0);

    // Counter saturation
    load_key(8'h11, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) send(8'($urandom), 1'b0);
    repeat (2) tick();
    chk("count_saturate", 32'(word_count), 15);

    // Reset mid-stream while a word is held
    m_ready = 1'b0;
    load_key(8'h33, 3'd1, 1'b0);
    send(8'h12, 1'b1);
    chk("pre_rst_m_valid", 32'(m_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 0);
    chk("async_rst_m_data", 32'(m_data), 0);
    chk("async_rst_m_last", 32'(m_last), 0);
    chk("async_rst_word_count", 32'(word_count), 0);
    chk("async_rst_s_ready", 32'(s_ready), 0);
    tick(); tick();
    rst_n = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    tick(); tick();
    chk("post_rst_s_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
    load_key(8'h77, 3'd5, 1'b1);
    chk("post_rst_ready_after_load", 32'(s_ready), 1);

    // Randomized traffic, including one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      key_load = ($urandom % 20) == 0;
      key      = 8'($urandom);
      shift    = 3'($urandom);
      mode     = 1'($urandom);
      s_valid  = ($urandom % 4) != 0;
      s_data   = 8'($urandom);
      s_last   = ($urandom % 4) == 0;
      m_ready  = ($urandom % 3) != 0;
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
      tick();
    end
    key_load = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
